ultrasonic_echo_responder: RTL and testbench
============================================

# ultrasonic_echo_responder

Synthesizable model of the HC-SR04 sensor side of the ultrasonic ranging link. It accepts the TRIG pulse produced by our trigger generator and answers with an ECHO pulse whose width encodes a programmed distance. It is used as the on-board stand-in for the physical sensor in loopback builds, and as the bus-functional responder in system benches for the echo timer and LED driver path.

## Interface
- CLK_FREQ_HZ, 12_000_000: clock frequency; CYC_PER_US = CLK_FREQ_HZ/1_000_000, an integer ≥ 2.
- TRIG_MIN_US, 10: minimum accepted TRIG high width, in µs.
- BURST_US, 200: delay from accepted TRIG fall to ECHO rise (8×40 kHz burst).
- US_PER_CM, 58: ECHO µs per cm of distance.
- MAX_CM, 400: largest in-range distance.
- TIMEOUT_US, 38_000: ECHO width for an out-of-range distance.
- HOLDOFF_US, 60_000: dead time after ECHO falls.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- TRIG  in  1  trigger from the initiator; asynchronous to clk.
- dist_cm  in  16  distance to report; sampled once per measurement.
- ECHO  out  1  echo pulse (registered).
- busy  out  1  high in BURST, ECHO_HI and HOLDOFF.
- trig_err  out  1  one-cycle pulse when a TRIG shorter than TRIG_MIN_US is rejected.

## Operation
- TRIG passes through a 2-flop synchronizer, followed by one edge-detect register. The FSM acts on edges of the synchronized signal, 3 clk after the pin changes.
- µs time base: a CYC_PER_US prescaler that restarts from 0 on every state transition. All durations are therefore exact multiples of CYC_PER_US clocks, measured from the transition.
- States:
  - IDLE: on a rising edge go to TRIG_HI.
  - TRIG_HI: count µs while TRIG is high.
    - Falling edge with count ≥ TRIG_MIN_US: latch dist_cm, go to BURST.
    - Falling edge with count < TRIG_MIN_US: pulse trig_err, go to IDLE.
    - A TRIG held high arbitrarily long is legal; the response starts only on the fall.
  - BURST: wait BURST_US, then go to ECHO_HI.
  - ECHO_HI: ECHO high for W µs, then go to HOLDOFF.
    - W = latched_cm × US_PER_CM when 1 ≤ latched_cm ≤ MAX_CM.
    - Otherwise (0 or > MAX_CM), W = TIMEOUT_US.
  - HOLDOFF: wait HOLDOFF_US, then go to WAIT_LOW.
  - WAIT_LOW: go to IDLE once synchronized TRIG is low. A rising edge is always required to start a measurement.
- TRIG activity in BURST, ECHO_HI and HOLDOFF is ignored; no trig_err is raised.
- dist_cm changes after latching have no effect on the current pulse.
- Arithmetic:
  - W is computed as cm_count × US_PER_CM without a multiplier: a µs counter counts up to US_PER_CM−1, and a cm counter counts down from latched_cm.
  - The µs counter width is sized for max(TIMEOUT_US, HOLDOFF_US, BURST_US, TRIG_MIN_US); it never wraps within a state.
  - A TRIG_HI count saturates at TRIG_MIN_US.

## Timing
- Reset: on the clk edge that samples rst=0:
  - ECHO=0, busy=0, trig_err=0.
  - State goes to WAIT_LOW and all counters clear.
  - This applies in any state, including mid-ECHO; an ECHO in progress is truncated on that edge.
- ECHO rises exactly BURST_US×CYC_PER_US clk after the cycle in which the FSM enters BURST. It stays high for exactly W×CYC_PER_US clk.
- busy:
  - Rises in the same cycle as the entry into BURST.
  - Falls on the HOLDOFF→WAIT_LOW transition.
- trig_err: asserted for one cycle, in the cycle the FSM returns to IDLE.
- TRIG high width is measured on the synchronized signal, so synchronizer latency cancels. Accepted width resolution is ±1 µs.

## Structure
- Package ultrasonic_pkg holds:
  - the state enum (IDLE, TRIG_HI, BURST, ECHO_HI, HOLDOFF, WAIT_LOW);
  - US_PER_CM and the default TIMEOUT_US, shared with echo_timer for consistent cm conversion.
- Sub-module us_tick_gen: parameterized CYC_PER_US prescaler with a restart input and a one-cycle tick output.
- Remaining logic (synchronizer, FSM, counters, output registers) is in ultrasonic_echo_responder.

## Test plan
All scenarios use CLK_FREQ_HZ=4_000_000, BURST_US=5, HOLDOFF_US=20 and TIMEOUT_US=500.
- TRIG high 12 µs, dist_cm=3 -> ECHO rises 20 clk after BURST entry and is high 696 clk (174 µs). busy falls 80 clk after ECHO falls.
- TRIG high 6 µs -> trig_err pulses once; ECHO and busy stay 0; the next 12 µs TRIG gives a normal response.
- dist_cm=0, then dist_cm=401 -> ECHO high 2000 clk each time.
- Latch dist_cm=2, change it to 9 during BURST -> ECHO width 464 clk. Extra TRIG pulses during ECHO cause no trig_err and no second ECHO.
- TRIG held high through the end of HOLDOFF -> no new measurement until TRIG goes low and then high again.
- rst=0 asserted mid-ECHO -> ECHO and busy are 0 on the next edge. After release, a TRIG that is already high is ignored until it cycles low.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging link: responder states and
// the cm/us conversion constants used by both the responder and echo_timer.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrigHi,
        StBurst,
        StEchoHi,
        StHoldoff,
        StWaitLow
    } state_e;

    localparam int unsigned DEF_US_PER_CM  = 58;
    localparam int unsigned DEF_TIMEOUT_US = 38_000;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CYC_PER_US clocks, restartable
// so that every duration is measured from the restart cycle.
module us_tick_gen #(
    parameter int unsigned CYC_PER_US = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = (CYC_PER_US > 2) ? $clog2(CYC_PER_US) : 1;
    localparam logic [W-1:0] LAST = W'(CYC_PER_US - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 sensor stand-in: answers an accepted TRIG pulse with an ECHO pulse
// whose width encodes the latched distance, then holds off before re-arming.
module ultrasonic_echo_responder
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned US_PER_CM   = DEF_US_PER_CM,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = DEF_TIMEOUT_US,
    parameter int unsigned HOLDOFF_US  = 60_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        TRIG,
    input  logic [15:0] dist_cm,
    output logic        ECHO,
    output logic        busy,
    output logic        trig_err
);

    localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned US_MAX =
        umax(umax(TIMEOUT_US, HOLDOFF_US), umax(umax(BURST_US, TRIG_MIN_US), US_PER_CM));
    localparam int unsigned US_W = $clog2(US_MAX + 1);

    localparam logic [US_W-1:0] TRIG_MIN_C   = US_W'(TRIG_MIN_US);
    localparam logic [US_W-1:0] BURST_LAST   = US_W'(BURST_US - 1);
    localparam logic [US_W-1:0] CM_LAST      = US_W'(US_PER_CM - 1);
    localparam logic [US_W-1:0] TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0] HOLDOFF_LAST = US_W'(HOLDOFF_US - 1);
    localparam logic [15:0]     MAX_CM_C     = 16'(MAX_CM);

    state_e          state_q, state_d;
    logic [US_W-1:0] us_q, us_d;
    logic [15:0]     cm_q, cm_d;
    logic            in_range_q, in_range_d;
    logic            err_d;
    logic            echo_q, busy_q, err_q;
    logic            trig_s1_q, trig_s2_q, trig_d_q;
    logic            trig_rise, trig_fall;
    logic            restart, tick;

    // Synchronizer is left out of reset so a TRIG held high across reset
    // release is seen as level, not as a fresh rising edge.
    always_ff @(posedge clk) begin
        trig_s1_q <= TRIG;
        trig_s2_q <= trig_s1_q;
        trig_d_q  <= trig_s2_q;
    end

    assign trig_rise = trig_s2_q & ~trig_d_q;
    assign trig_fall = ~trig_s2_q & trig_d_q;
    assign restart   = (state_d != state_q);

    us_tick_gen #(
        .CYC_PER_US(CYC_PER_US)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        us_d       = us_q;
        cm_d       = cm_q;
        in_range_d = in_range_q;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig_rise) begin
                    state_d = StTrigHi;
                end
            end
            StTrigHi: begin
                if (trig_fall) begin
                    if (us_q >= TRIG_MIN_C) begin
                        state_d    = StBurst;
                        cm_d       = dist_cm;
                        in_range_d = (dist_cm != 16'd0) && (dist_cm <= MAX_CM_C);
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end else if (tick && (us_q < TRIG_MIN_C)) begin
                    us_d = us_q + 1'b1;
                end
            end
            StBurst: begin
                if (tick) begin
                    if (us_q == BURST_LAST) begin
                        state_d = StEchoHi;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            StEchoHi: begin
                // In range: us counter walks one cm, cm counter counts cms down.
                if (tick) begin
                    if (in_range_q) begin
                        if (us_q == CM_LAST) begin
                            us_d = '0;
                            if (cm_q == 16'd1) begin
                                state_d = StHoldoff;
                            end else begin
                                cm_d = cm_q - 16'd1;
                            end
                        end else begin
                            us_d = us_q + 1'b1;
                        end
                    end else if (us_q == TIMEOUT_LAST) begin
                        state_d = StHoldoff;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            StHoldoff: begin
                if (tick) begin
                    if (us_q == HOLDOFF_LAST) begin
                        state_d = StWaitLow;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            StWaitLow: begin
                if (!trig_s2_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StWaitLow;
            end
        endcase
        if (state_d != state_q) begin
            us_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StWaitLow;
            us_q       <= '0;
            cm_q       <= '0;
            in_range_q <= 1'b0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            us_q       <= us_d;
            cm_q       <= cm_d;
            in_range_q <= in_range_d;
            echo_q     <= (state_d == StEchoHi);
            busy_q     <= (state_d == StBurst) || (state_d == StEchoHi) ||
                          (state_d == StHoldoff);
            err_q      <= err_d;
        end
    end

    assign ECHO     = echo_q;
    assign busy     = busy_q;
    assign trig_err = err_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder at 4 MHz: expected ECHO widths
// are queued when a TRIG is issued and compared as each ECHO pulse completes.
module tb_ultrasonic_echo_responder;

    localparam int CYC      = 4;
    localparam int BURST    = 5;
    localparam int HOLDOFF  = 20;
    localparam int TIMEOUT  = 500;
    localparam int USPERCM  = 58;
    localparam int MAXWAIT  = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        TRIG = 1'b0;
    logic [15:0] dist_cm = 16'd0;
    logic        ECHO, busy, trig_err;

    int tests = 0;
    int fails = 0;

    // Monitor-owned measurement records.
    int cyc = 0;
    int t_busy_rise = 0, t_echo_rise = 0, t_echo_fall = 0;
    int meas_w[64];
    int meas_rise[64];
    int meas_tail[64];
    int n_echo = 0, n_tail = 0, n_err = 0, n_busy = 0;
    logic echo_p = 1'b0, busy_p = 1'b0;

    // Bench-owned scoreboard state.
    int exp_q[$];
    int rd_echo = 0, rd_tail = 0;

    ultrasonic_echo_responder #(
        .CLK_FREQ_HZ(4_000_000),
        .BURST_US   (BURST),
        .HOLDOFF_US (HOLDOFF),
        .TIMEOUT_US (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .TRIG    (TRIG),
        .dist_cm (dist_cm),
        .ECHO    (ECHO),
        .busy    (busy),
        .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (busy && !busy_p) begin
            t_busy_rise <= cyc;
            n_busy      <= n_busy + 1;
        end
        if (ECHO && !echo_p) t_echo_rise <= cyc;
        if (!ECHO && echo_p && rst) begin
            meas_w[n_echo]    <= cyc - t_echo_rise;
            meas_rise[n_echo] <= t_echo_rise - t_busy_rise;
            t_echo_fall       <= cyc;
            n_echo            <= n_echo + 1;
        end
        if (!busy && busy_p && rst) begin
            meas_tail[n_tail] <= cyc - t_echo_fall;
            n_tail            <= n_tail + 1;
        end
        if (trig_err) n_err <= n_err + 1;
        echo_p <= ECHO;
        busy_p <= busy;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig(input int us);
        TRIG = 1'b1;
        step(us * CYC);
        TRIG = 1'b0;
    endtask

    task automatic wait_echo_high();
        int k = 0;
        while (!ECHO && k < MAXWAIT) begin
            step(1);
            k++;
        end
        tests++;
        if (!ECHO) begin
            fails++;
            $display("FAIL echo_start: ECHO=%0b after %0d clk, required 1", ECHO, k);
        end
    endtask

    // Pops one expected width and checks the completed pulse against it.
    task automatic expect_echo(input string name);
        int k = 0;
        int exp_w;
        while (n_echo <= rd_echo && k < MAXWAIT) begin
            step(1);
            k++;
        end
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        tests++;
        if (n_echo <= rd_echo) begin
            fails++;
            $display("FAIL %s_width: no ECHO pulse within %0d clk, required %0d", name, k, exp_w);
            return;
        end
        if (meas_w[rd_echo] !== exp_w) begin
            fails++;
            $display("FAIL %s_width: got %0d clk, required %0d", name, meas_w[rd_echo], exp_w);
        end
        tests++;
        if (meas_rise[rd_echo] !== BURST * CYC) begin
            fails++;
            $display("FAIL %s_rise: got %0d clk, required %0d",
                     name, meas_rise[rd_echo], BURST * CYC);
        end
        rd_echo++;
        k = 0;
        while (n_tail <= rd_tail && k < MAXWAIT) begin
            step(1);
            k++;
        end
        tests++;
        if (n_tail <= rd_tail) begin
            fails++;
            $display("FAIL %s_busy_tail: busy never fell, required %0d clk", name, HOLDOFF * CYC);
        end else begin
            if (meas_tail[rd_tail] !== HOLDOFF * CYC) begin
                fails++;
                $display("FAIL %s_busy_tail: got %0d clk, required %0d",
                         name, meas_tail[rd_tail], HOLDOFF * CYC);
            end
            rd_tail++;
        end
        step(10);
    endtask

    task automatic measure(input int cm, input int exp_w, input string name);
        dist_cm = 16'(cm);
        exp_q.push_back(exp_w);
        pulse_trig(12);
        expect_echo(name);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(6);
        tests++;
        if (ECHO !== 1'b0 || busy !== 1'b0 || trig_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ECHO=%0b busy=%0b trig_err=%0b, required 0 0 0",
                     ECHO, busy, trig_err);
        end
        rst = 1'b1;
        step(5);
    endtask

    task automatic test_basic();
        measure(3, 3 * USPERCM * CYC, "basic");
    endtask

    task automatic test_short_trig();
        int e0 = n_err;
        int b0 = n_busy;
        int c0 = n_echo;
        pulse_trig(6);
        step(20);
        tests++;
        if (n_err - e0 !== 1) begin
            fails++;
            $display("FAIL short_trig_err: got %0d trig_err cycles, required 1", n_err - e0);
        end
        tests++;
        if (n_busy !== b0 || n_echo !== c0) begin
            fails++;
            $display("FAIL short_trig_quiet: busy rises %0d echoes %0d, required 0 0",
                     n_busy - b0, n_echo - c0);
        end
        measure(3, 3 * USPERCM * CYC, "after_short");
    endtask

    task automatic test_out_of_range();
        measure(0, TIMEOUT * CYC, "cm0");
        measure(401, TIMEOUT * CYC, "cm401");
        measure(1, USPERCM * CYC, "cm1");
    endtask

    task automatic test_latch_and_ignore();
        int e0 = n_err;
        int c0 = n_echo;
        dist_cm = 16'd2;
        exp_q.push_back(2 * USPERCM * CYC);
        pulse_trig(12);
        step(4);
        dist_cm = 16'd9;
        wait_echo_high();
        pulse_trig(12);
        step(20);
        pulse_trig(3);
        expect_echo("latch");
        step(100);
        tests++;
        if (n_err !== e0) begin
            fails++;
            $display("FAIL ignore_err: got %0d trig_err cycles, required 0", n_err - e0);
        end
        tests++;
        if (n_echo - c0 !== 1) begin
            fails++;
            $display("FAIL ignore_echo: got %0d ECHO pulses, required 1", n_echo - c0);
        end
    endtask

    task automatic test_held_high();
        int b0;
        dist_cm = 16'd3;
        exp_q.push_back(3 * USPERCM * CYC);
        pulse_trig(12);
        wait_echo_high();
        TRIG = 1'b1;
        expect_echo("held");
        b0 = n_busy;
        step(200);
        tests++;
        if (n_busy !== b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL held_no_rearm: busy rises %0d busy=%0b, required 0 0",
                     n_busy - b0, busy);
        end
        TRIG = 1'b0;
        step(10);
        measure(3, 3 * USPERCM * CYC, "after_held");
    endtask

    task automatic test_reset_mid_echo();
        int b0;
        dist_cm = 16'd3;
        pulse_trig(12);
        wait_echo_high();
        step(10);
        TRIG = 1'b1;
        rst  = 1'b0;
        step(1);
        tests++;
        if (ECHO !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_echo: ECHO=%0b busy=%0b, required 0 0", ECHO, busy);
        end
        step(5);
        rst = 1'b1;
        b0 = n_busy;
        step(200);
        tests++;
        if (n_busy !== b0 || ECHO !== 1'b0) begin
            fails++;
            $display("FAIL reset_high_trig: busy rises %0d ECHO=%0b, required 0 0",
                     n_busy - b0, ECHO);
        end
        TRIG = 1'b0;
        step(10);
        measure(2, 2 * USPERCM * CYC, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_trig();
        test_out_of_range();
        test_latch_and_ignore();
        test_held_high();
        test_reset_mid_echo();
        tests++;
        if (exp_q.size() !== 0 || n_echo !== rd_echo) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected left, %0d unchecked pulses, required 0 0",
                     exp_q.size(), n_echo - rd_echo);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
